// File: rtl/ccc_rstseq_pkg.sv
// Shared types and counter-width helpers for the CCC lock/reset sequencer.
package ccc_rstseq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILISE,
    RELEASE,
    RUN
  } state_t;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The first stable cycle is seen in WAIT_LOCK, so the counter tops out at cycles-2.
  function automatic int stab_cnt_w(input int lock_stable_cycles);
    return cnt_w(lock_stable_cycles - 1);
  endfunction

  function automatic int stagger_cnt_w(input int stagger_cycles);
    return cnt_w(stagger_cycles);
  endfunction

  function automatic int loss_cnt_w(input int loss_filter);
    return cnt_w(loss_filter);
  endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// LOCK synchroniser plus loss filter: emits a one-cycle loss_evt once lock_s has
// been low for loss_filter consecutive cycles while the filter is enabled.
module ccc_lock_sync
  import ccc_rstseq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOSS_FILTER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_in,
  input  logic en,
  output logic lock_s,
  output logic loss_evt
);

  localparam int LW = loss_cnt_w(LOSS_FILTER);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_FILTER - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [LW-1:0]          loss_cnt;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchroniser chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // The current low cycle counts, so the event fires on the LOSS_FILTER-th low cycle.
  assign loss_evt = en && !lock_s && (loss_cnt == LOSS_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          loss_cnt <= '0;
    else if (!en || lock_s || loss_evt) loss_cnt <= '0;
    else                              loss_cnt <= loss_cnt + LW'(1);
  end

endmodule

// File: rtl/ccc_lock_rst_sequencer.sv
// Lock supervisor: waits for a stable CCC lock, releases domain resets in
// ascending order, and re-asserts them all on filtered lock loss or software request.
module ccc_lock_rst_sequencer
  import ccc_rstseq_pkg::*;
#(
  parameter int NUM_CH             = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 16,
  parameter int LOSS_FILTER        = 4,
  parameter int CNT_W              = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOCK_IN,
  input  logic              SW_RESET_REQ,
  input  logic              CLEAR_STATUS,
  output logic [NUM_CH-1:0] RST_OUT,
  output logic              READY,
  output logic              LOCK_LOST_STICKY,
  output logic [CNT_W-1:0]  LOCK_LOSS_CNT
);

  localparam int SW = stab_cnt_w(LOCK_STABLE_CYCLES);
  localparam int GW = stagger_cnt_w(STAGGER_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE_CYCLES - 2);
  localparam logic [GW-1:0] STG_MAX  = GW'(STAGGER_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SW-1:0]      stab_q, stab_d;
  logic [GW-1:0]      stg_q, stg_d;
  logic [NUM_CH-1:0]  rst_q, rst_d, shifted;
  logic               ready_q, ready_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic               lock_s, loss_evt, filt_en;

  assign filt_en = (state_q == RELEASE) || (state_q == RUN);

  ccc_lock_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .LOSS_FILTER (LOSS_FILTER)
  ) u_sync (
    .clk      (CLK),
    .rst      (RESET),
    .lock_in  (LOCK_IN),
    .en       (filt_en),
    .lock_s   (lock_s),
    .loss_evt (loss_evt)
  );

  // NOTE: every signal driven here gets a default before any branch, otherwise
  // a path that skips an assignment infers a latch.
  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    stg_d    = stg_q;
    rst_d    = rst_q;
    ready_d  = ready_q;
    shifted  = rst_q << 1;

    // Status: a loss in the same cycle as a clear still registers as one loss.
    cnt_base = CLEAR_STATUS ? '0 : cnt_q;
    sticky_d = sticky_q && !CLEAR_STATUS;
    cnt_d    = cnt_base;
    if (loss_evt) begin
      sticky_d = 1'b1;
      if (cnt_base != '1) cnt_d = cnt_base + CNT_W'(1);
    end

    case (state_q)
      WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        stab_d  = '0;
        if (lock_s) state_d = STABILISE;
      end
      STABILISE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (SW_RESET_REQ) begin
          stab_d = '0;
        end else if (stab_q == STAB_MAX) begin
          rst_d = shifted;
          stg_d = '0;
          if (shifted == '0) begin
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      RELEASE, RUN: begin
        if (loss_evt || SW_RESET_REQ) begin
          rst_d   = '1;
          ready_d = 1'b0;
          stab_d  = '0;
          stg_d   = '0;
          state_d = WAIT_LOCK;
        end else if (state_q == RELEASE) begin
          if (stg_q == STG_MAX) begin
            stg_d = '0;
            rst_d = shifted;
            if (shifted == '0) begin
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            stg_d = stg_q + GW'(1);
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= WAIT_LOCK;
      stab_q   <= '0;
      stg_q    <= '0;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stab_q   <= stab_d;
      stg_q    <= stg_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign RST_OUT          = rst_q;
  assign READY            = ready_q;
  assign LOCK_LOST_STICKY = sticky_q;
  assign LOCK_LOSS_CNT    = cnt_q;

endmodule

// File: tb/tb_ccc_lock_rst_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle;
// a negedge monitor pops and compares whenever the outputs change.
module tb_ccc_lock_rst_sequencer;

  typedef struct packed {
    logic [2:0] rst;
    logic       ready;
    logic       sticky;
    logic [2:0] cnt;
  } obs_t;

  typedef struct {
    int   at;
    obs_t val;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       LOCK_IN = 1'b0;
  logic       SW_RESET_REQ = 1'b0;
  logic       CLEAR_STATUS = 1'b0;
  logic [2:0] RST_OUT;
  logic       READY;
  logic       LOCK_LOST_STICKY;
  logic [2:0] LOCK_LOSS_CNT;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   mon_first = 1'b1;
  obs_t prev;
  obs_t m;
  exp_t exp_q[$];

  ccc_lock_rst_sequencer #(
    .NUM_CH             (3),
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .STAGGER_CYCLES     (4),
    .LOSS_FILTER        (2),
    .CNT_W              (3)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .LOCK_IN          (LOCK_IN),
    .SW_RESET_REQ     (SW_RESET_REQ),
    .CLEAR_STATUS     (CLEAR_STATUS),
    .RST_OUT          (RST_OUT),
    .READY            (READY),
    .LOCK_LOST_STICKY (LOCK_LOST_STICKY),
    .LOCK_LOSS_CNT    (LOCK_LOSS_CNT)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every observed change of the output bundle consumes one expectation.
  always @(negedge CLK) begin
    obs_t cur;
    exp_t e;
    cur = {RST_OUT, READY, LOCK_LOST_STICKY, LOCK_LOSS_CNT};
    if (mon_en && (mon_first || cur != prev)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change: got 0x%0h with nothing expected (cycle %0d)", cur, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ev_value", int'(cur), int'(e.val));
        check("ev_cycle", cyc, e.at);
      end
      mon_first = 1'b0;
    end
    prev = cur;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input int at);
    exp_t e;
    e.at  = at;
    e.val = m;
    exp_q.push_back(e);
  endtask

  // LOCK_IN rose in cycle c with the FSM idle in WAIT_LOCK: 2 sync + 8 stable, then 4-cycle stagger.
  task automatic push_release(input int c);
    m.rst = 3'b110;                 push(c + 10);
    m.rst = 3'b100;                 push(c + 14);
    m.rst = 3'b000; m.ready = 1'b1; push(c + 18);
  endtask

  initial begin
    int c;
    #1 RESET = 1'b1;
    step(2);
    m = '{rst: 3'b111, ready: 1'b0, sticky: 1'b0, cnt: 3'd0};
    push(cyc);
    mon_en = 1'b1;
    RESET  = 1'b0;
    step(2);

    // Power-up release.
    c = cyc;
    LOCK_IN = 1'b1;
    push_release(c);
    step(20);

    // Software re-run from RUN while lock is dropped: no count, no sticky.
    c = cyc;
    SW_RESET_REQ = 1'b1;
    LOCK_IN      = 1'b0;
    m.rst = 3'b111; m.ready = 1'b0;
    push(c + 1);
    step(1);
    SW_RESET_REQ = 1'b0;
    step(4);

    // Lock bounce after 5 stable cycles restarts stabilisation from zero.
    LOCK_IN = 1'b1;
    step(5);
    LOCK_IN = 1'b0;
    step(1);
    LOCK_IN = 1'b1;
    push_release(cyc);
    step(20);

    // 1-cycle glitch in RUN is filtered out.
    LOCK_IN = 1'b0;
    step(1);
    LOCK_IN = 1'b1;
    step(6);

    // 3-cycle loss in RUN: resets two cycles after lock_s falls, then re-lock.
    c = cyc;
    LOCK_IN = 1'b0;
    m = '{rst: 3'b111, ready: 1'b0, sticky: 1'b1, cnt: 3'd1};
    push(c + 4);
    step(3);
    LOCK_IN = 1'b1;
    push_release(cyc);
    step(20);

    // Nine more losses, each cutting the next sequence right after RST_OUT[0] falls.
    for (int i = 0; i < 9; i++) begin
      c = cyc;
      LOCK_IN = 1'b0;
      m.rst = 3'b111; m.ready = 1'b0; m.sticky = 1'b1;
      if (m.cnt != 3'd7) m.cnt = m.cnt + 3'd1;
      push(c + 4);
      step(3);
      LOCK_IN = 1'b1;
      m.rst = 3'b110;
      push(cyc + 10);
      step(10);
    end

    // Clear coinciding with a loss event: the loss wins, count restarts at 1.
    c = cyc;
    LOCK_IN = 1'b0;
    m = '{rst: 3'b111, ready: 1'b0, sticky: 1'b1, cnt: 3'd1};
    push(c + 4);
    step(3);
    CLEAR_STATUS = 1'b1;
    LOCK_IN      = 1'b1;
    push_release(cyc);
    step(1);
    CLEAR_STATUS = 1'b0;
    step(19);

    // SW request one cycle after RST_OUT[0] falls, then RESET mid-RELEASE.
    c = cyc;
    SW_RESET_REQ = 1'b1;
    m.rst = 3'b111; m.ready = 1'b0;
    push(c + 1);
    step(1);
    SW_RESET_REQ = 1'b0;
    m.rst = 3'b110;
    push(c + 9);
    step(9);
    SW_RESET_REQ = 1'b1;
    m.rst = 3'b111;
    push(c + 11);
    step(1);
    SW_RESET_REQ = 1'b0;
    m.rst = 3'b110;
    push(c + 19);
    step(10);
    RESET = 1'b1;
    m = '{rst: 3'b111, ready: 1'b0, sticky: 1'b0, cnt: 3'd0};
    push(c + 21);
    step(2);
    RESET = 1'b0;
    push_release(cyc);
    step(22);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
